uart_rx_byte: RTL
=================

Name: uart_rx_byte

Overview:
- Serial-to-parallel front end for the 8-bit hold latch stage.
- Receives asynchronous 8N1 serial frames on one input pin.
- Drives `data` straight into the latch data input and a one-cycle `load` strobe into the latch enable.
- Flags malformed frames. Sits between the TinyTapeout input pin and the byte latch.

Parameters:
- CLKS_PER_BIT, 1042: clock cycles per serial bit (e.g. 10 MHz / 9600 baud). Legal range 4..65535. Bench uses 8.
- HALF_BIT, CLKS_PER_BIT/2 (integer floor): cycles from detected start edge to start-bit mid-sample.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, synchronous, active-high.
- rx  input  1  asynchronous serial line, idle high, LSB first.
- data  output  8  last correctly framed byte. Feeds the latch `d` input.
- load  output  1  one-cycle strobe when `data` is updated. Feeds the latch `en` input.
- frame_err  output  1  sticky: last frame had a bad stop bit. Cleared by the next good frame or by reset.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Input synchronizer:
  - `rx` passes through a 2-flop synchronizer (reset value 1) before any use. The synchronized signal is rx_s.
  - All timing below is relative to rx_s.
- Reset (rst high at a clock edge):
  - state=IDLE; data=0x00; load=0; frame_err=0; busy=0; bit counter=0; cycle counter=0; shift register=0; synchronizer flops=1.
  - Reset mid-frame abandons the frame with no load and no frame_err.
- State machine: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - The cycle rx_s=0 is seen, go to START with cycle counter=0.
- START:
  - Count cycles. When counter reaches HALF_BIT-1, sample rx_s.
  - rx_s=1: false start (glitch). Go to IDLE with no outputs changed.
  - rx_s=0: counter=0, bit index=0, go to DATA.
- DATA:
  - Count to CLKS_PER_BIT-1, then sample rx_s into shift register bit[index] (LSB first) and reset the counter.
  - After index 7 is sampled, go to STOP.
- STOP:
  - Count to CLKS_PER_BIT-1, then sample rx_s.
  - rx_s=1: on the next edge data<=shift register, load=1 for exactly one cycle, frame_err<=0, go to IDLE.
  - rx_s=0: frame_err<=1, data unchanged, no load, go to BREAK.
- BREAK:
  - Stay until rx_s=1, then go to IDLE.
  - A held-low line (break) produces exactly one frame_err and no spurious start.
- load:
  - Never high for more than one consecutive cycle.
  - Never high in the same cycle as rst.
- data: changes only on the cycle load rises; stable at all other times.
- Timing:
  - Stop-bit sample point = first rx_s low cycle + HALF_BIT + 9*CLKS_PER_BIT (+/-1).
  - load asserts one cycle after the stop sample.
- Back-to-back frames:
  - Returning to IDLE at mid-stop-bit lets a start bit that directly follows a single stop bit be detected.
  - No minimum idle time between frames.
- Counter width: ceil(log2(CLKS_PER_BIT)) bits. Counters never wrap mid-bit; each is cleared at every sample point.
- busy: high from the cycle after start detection until the cycle the state returns to IDLE.
- rx changes during the DATA/STOP counting windows between sample points are ignored (mid-bit sampling only, no majority vote).

Test Plan (CLKS_PER_BIT=8, HALF_BIT=4):
- Reset, then a frame for 0xA5 with a valid stop bit -> data=0xA5; load high exactly 1 cycle about 77 cycles after the start edge on rx_s; frame_err=0; busy low afterwards.
- After 0xA5, send a frame for 0x3C with stop bit=0 -> no load; data stays 0xA5; frame_err=1. Then a valid 0x3C frame -> data=0x3C, load pulse, frame_err=0.
- Glitch: rx low for 2 cycles, then high -> state returns to IDLE; no load; frame_err=0; data unchanged.
- Back-to-back 0x00 then 0xFF, one stop bit each, no idle gap -> two load pulses with data 0x00 then 0xFF, each stable until the next pulse.
- Break: rx held low for 20 bit times, then high -> frame_err=1 exactly once; no load; next valid 0x55 frame -> data=0x55, frame_err=0.
- Assert rst for 1 cycle during DATA bit 4 of a 0x81 frame -> data=0x00, load=0, busy=0 next cycle; the trailing bits of the aborted frame produce no load; a following clean 0x81 frame -> data=0x81.

Source files
------------

// File: rtl/uart_rx_byte.sv
// 8N1 serial receiver feeding the byte hold latch: mid-bit sampling, one-cycle load strobe,
// sticky framing-error flag and break detection.
`timescale 1ns/1ps
module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 1042,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       load,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfLast = CntW'(HALF_BIT - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e          state_q;
    logic            rx_meta_q;
    logic            rx_s_q;
    logic [1:0]      sync_fill_q;
    logic            armed_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      idx_q;
    logic [7:0]      shift_q;
    logic [7:0]      data_q;
    logic            load_q;
    logic            frame_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            sync_fill_q <= 2'b00;
            armed_q     <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            load_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            sync_fill_q <= {sync_fill_q[0], 1'b1};
            // Start bits are only accepted after the real line has been seen idle-high, so a
            // reset in mid-frame does not resynchronise onto the tail of the abandoned frame.
            if (sync_fill_q[1] && rx_s_q) begin
                armed_q <= 1'b1;
            end
            load_q <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (armed_q && !rx_s_q) begin
                        cnt_q   <= '0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (cnt_q == HalfLast) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            state_q <= StIdle;
                        end else begin
                            idx_q   <= '0;
                            state_q <= StData;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StData: begin
                    if (cnt_q == BitLast) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rx_s_q;
                        idx_q          <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_q <= StStop;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StStop: begin
                    if (cnt_q == BitLast) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            data_q      <= shift_q;
                            load_q      <= 1'b1;
                            frame_err_q <= 1'b0;
                            state_q     <= StIdle;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= StBreak;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StBreak: begin
                    if (rx_s_q) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign data      = data_q;
    assign load      = load_q & ~rst;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != StIdle);

endmodule
